// File: rtl/jk_pkg.sv
// Shared definitions for the JK command sequencer: op codes, FSM states and
// the queued command payload.
package jk_pkg;

   localparam int unsigned JK_CNT_W = 4;

   localparam logic [1:0] JK_HOLD   = 2'b00;
   localparam logic [1:0] JK_RESET  = 2'b01;
   localparam logic [1:0] JK_SET    = 2'b10;
   localparam logic [1:0] JK_TOGGLE = 2'b11;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   typedef struct packed {
      logic [1:0]          op;
      logic [JK_CNT_W-1:0] len;
   } cmd_t;

endpackage

// File: rtl/jk_cmd_sequencer_if.sv
// Command handshake between a command source and the JK sequencer.
interface jk_cmd_sequencer_if #(
   parameter int unsigned CNT_W = jk_pkg::JK_CNT_W
) ();

   logic             cmd_valid;
   logic             cmd_ready;
   logic [1:0]       cmd_op;
   logic [CNT_W-1:0] cmd_len;

   modport master (output cmd_valid, output cmd_op, output cmd_len, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_op, input cmd_len, output cmd_ready);

endinterface

// File: rtl/jk_cmd_fifo.sv
// Synchronous FIFO holding packed {op,len} commands; no fall-through, so a
// word written into an empty FIFO is readable from the following cycle.
module jk_cmd_fifo #(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned W     = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         i_push,
   input  logic [W-1:0] i_wdata,
   input  logic         i_pop,
   output logic [W-1:0] o_rdata,
   output logic         o_full,
   output logic         o_empty
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [W-1:0]  r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic          w_do_push;
   logic          w_do_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push & ~o_full;
   assign w_do_pop  = i_pop & ~o_empty;
   assign o_rdata   = r_mem[r_rd_ptr];

   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
   end

   // Pointers wrap naturally; a push on a full FIFO stays blocked even with a pop.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/jk_cmd_sequencer.sv
// Queues {op,len} commands and drives the JK cell's j/k for len+1 cycles each,
// keeping a registered shadow of the cell's q.
module jk_cmd_sequencer
   import jk_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   parameter int unsigned CNT_W = JK_CNT_W
) (
   input  logic              clk,
   input  logic              rst,
   jk_cmd_sequencer_if.slave cmd,
   output logic              j,
   output logic              k,
   output logic              busy,
   output logic              done,
   output logic              q_model
);

   localparam int unsigned CMD_W = 2 + CNT_W;

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_j;
   logic             r_k;
   logic             r_q;
   logic             r_done;
   logic             r_rst_q;

   logic             w_full;
   logic             w_empty;
   logic             w_push;
   logic             w_pop;
   logic [CMD_W-1:0] w_head;
   logic [1:0]       w_head_op;
   logic [CNT_W-1:0] w_head_len;

   // Held low through reset and for the first cycle after release.
   assign cmd.cmd_ready = ~rst & ~r_rst_q & ~w_full;
   assign w_push        = cmd.cmd_valid & cmd.cmd_ready;
   assign w_pop         = ~w_empty & ((r_state == IDLE) | (r_cnt == '0));
   assign w_head_op     = w_head[CMD_W-1 -: 2];
   assign w_head_len    = w_head[CNT_W-1:0];

   jk_cmd_fifo #(
      .DEPTH (DEPTH),
      .W     (CMD_W)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_push  (w_push),
      .i_wdata ({cmd.cmd_op, cmd.cmd_len}),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   always_ff @(posedge clk) begin
      r_rst_q <= rst;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_j     <= 1'b0;
         r_k     <= 1'b0;
         r_q     <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_done <= 1'b0;
         // Mirror of the JK cell clocked with the currently driven inputs.
         case ({r_j, r_k})
            JK_RESET:  r_q <= 1'b0;
            JK_SET:    r_q <= 1'b1;
            JK_TOGGLE: r_q <= ~r_q;
            default:   r_q <= r_q;
         endcase
         case (r_state)
            IDLE: begin
               if (w_pop) begin
                  {r_j, r_k} <= w_head_op;
                  r_cnt      <= w_head_len;
                  r_state    <= RUN;
               end else begin
                  {r_j, r_k} <= 2'b00;
               end
            end
            RUN: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - CNT_W'(1);
               end else if (w_pop) begin
                  {r_j, r_k} <= w_head_op;
                  r_cnt      <= w_head_len;
               end else begin
                  {r_j, r_k} <= 2'b00;
                  r_done     <= 1'b1;
                  r_state    <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign j       = r_j;
   assign k       = r_k;
   assign q_model = r_q;
   assign done    = r_done;
   assign busy    = (r_state == RUN);

endmodule

// File: tb/tb_jk_cmd_sequencer.sv
// Directed bench for jk_cmd_sequencer: hand-computed j/k/q/done traces per scenario.
module tb_jk_cmd_sequencer;

   logic clk;
   logic rst;
   logic j, k, busy, done, q_model;

   int n_checks = 0;
   int n_pass   = 0;

   logic [1:0] c_op  [8];
   logic [3:0] c_len [8];
   int         c_n;
   logic [1:0] tr_jk   [32];
   logic       tr_rdy  [32];
   logic       tr_done [32];
   logic       tr_q    [32];
   int         acc_edge [8];
   int         n_acc;

   jk_cmd_sequencer_if #(.CNT_W(4)) cmd_if ();

   jk_cmd_sequencer #(.DEPTH(4), .CNT_W(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .cmd     (cmd_if),
      .j       (j),
      .k       (k),
      .busy    (busy),
      .done    (done),
      .q_model (q_model)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Offers c_op/c_len in order with valid held, recording outputs after every edge.
   task automatic run_cmds(input int ncyc);
      int   idx;
      logic rdy;
      idx = 0;
      for (int c = 0; c < ncyc; c++) begin
         cmd_if.cmd_valid = (idx < c_n);
         if (idx < c_n) begin
            cmd_if.cmd_op  = c_op[idx];
            cmd_if.cmd_len = c_len[idx];
         end
         rdy = cmd_if.cmd_ready;
         tick();
         if (cmd_if.cmd_valid && rdy) begin
            acc_edge[idx] = c;
            idx++;
         end
         tr_jk[c]   = {j, k};
         tr_rdy[c]  = cmd_if.cmd_ready;
         tr_done[c] = done;
         tr_q[c]    = q_model;
      end
      cmd_if.cmd_valid = 1'b0;
      n_acc = idx;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      cmd_if.cmd_valid = 1'b0;
      tick();
      tick();
      n_checks++;
      if ({j, k, q_model, busy, done} !== 5'b00000)
         $display("FAIL reset_outs: got %b exp 00000", {j, k, q_model, busy, done});
      else n_pass++;
      n_checks++;
      if (cmd_if.cmd_ready !== 1'b0) $display("FAIL reset_ready: got %b exp 0", cmd_if.cmd_ready);
      else n_pass++;
      rst = 1'b0;
      #1;
      n_checks++;
      if (cmd_if.cmd_ready !== 1'b0) $display("FAIL release_ready: got %b exp 0", cmd_if.cmd_ready);
      else n_pass++;
      tick();
      n_checks++;
      if (cmd_if.cmd_ready !== 1'b1) $display("FAIL post_release_ready: got %b exp 1", cmd_if.cmd_ready);
      else n_pass++;
   endtask

   task automatic test_toggle();
      logic [4:0] exp_v [5];
      // {j,k,q_model,busy,done} after edges E1..E5
      exp_v = '{5'b11010, 5'b11110, 5'b11010, 5'b11110, 5'b00001};
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = 2'b11;
      cmd_if.cmd_len   = 4'd3;
      tick();
      cmd_if.cmd_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b0) $display("FAIL toggle_no_fallthrough: busy got %b exp 0", busy);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         tick();
         n_checks++;
         if ({j, k, q_model, busy, done} !== exp_v[i])
            $display("FAIL toggle_cyc%0d: got %b exp %b", i + 1, {j, k, q_model, busy, done}, exp_v[i]);
         else n_pass++;
      end
      tick();
      n_checks++;
      if (done !== 1'b0) $display("FAIL toggle_done_once: got %b exp 0", done);
      else n_pass++;
   endtask

   task automatic test_single_set();
      logic [4:0] exp_v [3];
      exp_v = '{5'b10010, 5'b00101, 5'b00100};
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = 2'b10;
      cmd_if.cmd_len   = 4'd0;
      tick();
      cmd_if.cmd_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++;
         if ({j, k, q_model, busy, done} !== exp_v[i])
            $display("FAIL set_cyc%0d: got %b exp %b", i + 1, {j, k, q_model, busy, done}, exp_v[i]);
         else n_pass++;
      end
   endtask

   task automatic test_back_to_back();
      logic [2:0] exp_v [16];
      // HOLD/5 keeps the FSM busy so the four real commands fill the FIFO.
      c_op  = '{2'b00, 2'b10, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00, 2'b00};
      c_len = '{4'd5, 4'd0, 4'd1, 4'd0, 4'd2, 4'd0, 4'd0, 4'd0};
      c_n   = 5;
      // {j,k,done} after edges E0..E15
      exp_v = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b100,
                3'b000, 3'b000, 3'b010, 3'b110, 3'b110, 3'b110, 3'b001, 3'b000};
      run_cmds(16);
      n_checks++;
      if (n_acc !== 5) $display("FAIL b2b_accepted: got %0d exp 5", n_acc);
      else n_pass++;
      n_checks++;
      if (acc_edge[4] !== 4) $display("FAIL b2b_last_accept_edge: got %0d exp 4", acc_edge[4]);
      else n_pass++;
      n_checks++;
      if (tr_rdy[4] !== 1'b0) $display("FAIL b2b_ready_full: got %b exp 0", tr_rdy[4]);
      else n_pass++;
      n_checks++;
      if (tr_rdy[7] !== 1'b1) $display("FAIL b2b_ready_after_pop: got %b exp 1", tr_rdy[7]);
      else n_pass++;
      for (int c = 0; c < 16; c++) begin
         n_checks++;
         if ({tr_jk[c], tr_done[c]} !== exp_v[c])
            $display("FAIL b2b_E%0d: got %b exp %b", c, {tr_jk[c], tr_done[c]}, exp_v[c]);
         else n_pass++;
      end
      n_checks++;
      if (tr_q[15] !== 1'b1) $display("FAIL b2b_final_q: got %b exp 1", tr_q[15]);
      else n_pass++;
   endtask

   task automatic test_reset_mid_run();
      cmd_if.cmd_valid = 1'b1;
      cmd_if.cmd_op    = 2'b11;
      cmd_if.cmd_len   = 4'd15;
      tick();
      cmd_if.cmd_valid = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      n_checks++;
      if ({j, k, q_model, busy} !== 4'b1111)
         $display("FAIL midrun_before: got %b exp 1111", {j, k, q_model, busy});
      else n_pass++;
      rst = 1'b1;
      tick();
      n_checks++;
      if ({j, k, q_model, busy, done, cmd_if.cmd_ready} !== 6'b000000)
         $display("FAIL midrun_reset: got %b exp 000000", {j, k, q_model, busy, done, cmd_if.cmd_ready});
      else n_pass++;
      rst = 1'b0;
      tick();
      n_checks++;
      if ({busy, done, cmd_if.cmd_ready} !== 3'b001)
         $display("FAIL midrun_release: got %b exp 001", {busy, done, cmd_if.cmd_ready});
      else n_pass++;
      tick();
      n_checks++;
      if ({j, k, busy, done} !== 4'b0000)
         $display("FAIL midrun_queue_empty: got %b exp 0000", {j, k, busy, done});
      else n_pass++;
      test_single_set();
   endtask

   task automatic test_backpressure();
      logic [2:0] exp_v [19];
      c_op  = '{2'b00, 2'b10, 2'b01, 2'b11, 2'b10, 2'b00, 2'b00, 2'b00};
      c_len = '{4'd9, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0, 4'd0, 4'd0};
      c_n   = 6;
      exp_v = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
                3'b000, 3'b000, 3'b000, 3'b100, 3'b010, 3'b110, 3'b100, 3'b100,
                3'b000, 3'b001, 3'b000};
      run_cmds(19);
      n_checks++;
      if (n_acc !== 6) $display("FAIL bp_accepted: got %0d exp 6", n_acc);
      else n_pass++;
      n_checks++;
      if (acc_edge[5] !== 12) $display("FAIL bp_fifth_accept_edge: got %0d exp 12", acc_edge[5]);
      else n_pass++;
      for (int c = 4; c <= 11; c++) begin
         n_checks++;
         if (tr_rdy[c] !== (c == 11))
            $display("FAIL bp_ready_E%0d: got %b exp %b", c, tr_rdy[c], (c == 11));
         else n_pass++;
      end
      for (int c = 0; c < 19; c++) begin
         n_checks++;
         if ({tr_jk[c], tr_done[c]} !== exp_v[c])
            $display("FAIL bp_E%0d: got %b exp %b", c, {tr_jk[c], tr_done[c]}, exp_v[c]);
         else n_pass++;
      end
      n_checks++;
      if (tr_q[18] !== 1'b1) $display("FAIL bp_final_q: got %b exp 1", tr_q[18]);
      else n_pass++;
   endtask

   initial begin
      rst              = 1'b1;
      cmd_if.cmd_valid = 1'b0;
      cmd_if.cmd_op    = 2'b00;
      cmd_if.cmd_len   = 4'd0;
      test_reset();
      test_toggle();
      test_single_set();
      test_back_to_back();
      test_reset_mid_run();
      test_backpressure();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
